// File: rtl/vga_fb_arbiter.sv
// Cell framebuffer arbiter: just-in-time display prefetch with top priority,
// round-robin req/ack write service for two game-logic requesters in the spare RAM cycles.
module vga_fb_arbiter #(
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned COLS    = 80,
  parameter int unsigned ROWS    = 60,
  parameter int unsigned ADDR_W  = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               wr_req0,
  input  logic [ADDR_W-1:0]  wr_addr0,
  input  logic [COLOR_W-1:0] wr_data0,
  output logic               wr_ack0,
  input  logic               wr_req1,
  input  logic [ADDR_W-1:0]  wr_addr1,
  input  logic [COLOR_W-1:0] wr_data1,
  output logic               wr_ack1,
  output logic               wr_err,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] pix_color
);

  localparam int unsigned CELLS = COLS * ROWS;

  logic               r_rr_ptr;
  logic               r_pre0_done;
  logic               r_rd_pend;
  logic [COLOR_W-1:0] r_nxt_q;
  logic [COLOR_W-1:0] r_cell_q;
  logic [COLOR_W-1:0] r_pix_color;
  logic [ADDR_W-1:0]  r_last_addr;

  logic [ADDR_W-1:0]  w_row;
  logic [ADDR_W-1:0]  w_row_base;
  logic [ADDR_W-1:0]  w_disp_addr;
  logic               w_pre0;
  logic               w_fetch;
  logic               w_disp;
  logic               w_both;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_gnt;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic               w_in_range;

  // Row base = row*80 built from shifts; the fetch reads one cell ahead of scan-out.
  assign w_row       = ADDR_W'(y[9:3]);
  assign w_row_base  = (w_row << 6) + (w_row << 4);
  assign w_pre0      = !reset && !active && (y < 10'd480) && !r_pre0_done;
  assign w_fetch     = !reset && active && (x[2:0] == 3'd5) && (x < 10'd632);
  assign w_disp      = w_pre0 || w_fetch;
  assign w_disp_addr = w_fetch ? (w_row_base + ADDR_W'(x[9:3]) + ADDR_W'(1)) : w_row_base;

  // rr_ptr only decides contested cycles; a lone requester always wins a free slot.
  assign w_both     = wr_req0 && wr_req1;
  assign w_gnt0     = !reset && !w_disp && wr_req0 && (!wr_req1 || !r_rr_ptr);
  assign w_gnt1     = !reset && !w_disp && wr_req1 && (!wr_req0 || r_rr_ptr);
  assign w_gnt      = w_gnt0 || w_gnt1;
  assign w_gnt_addr = w_gnt1 ? wr_addr1 : wr_addr0;
  assign w_in_range = w_gnt_addr < ADDR_W'(CELLS);

  always_comb begin
    mem_addr  = r_last_addr;
    mem_we    = 1'b0;
    mem_wdata = w_gnt1 ? wr_data1 : wr_data0;
    wr_ack0   = w_gnt0;
    wr_ack1   = w_gnt1;
    wr_err    = 1'b0;
    if (w_disp) begin
      mem_addr = w_disp_addr;
    end else if (w_gnt) begin
      mem_addr = w_gnt_addr;
      mem_we   = w_in_range;
      wr_err   = !w_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= 1'b0;
      r_pre0_done <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_nxt_q     <= '0;
      r_cell_q    <= '0;
      r_pix_color <= '0;
      r_last_addr <= '0;
    end else begin
      if (w_gnt && w_both) r_rr_ptr <= ~r_rr_ptr;
      if (active)      r_pre0_done <= 1'b0;
      else if (w_pre0) r_pre0_done <= 1'b1;
      r_rd_pend <= w_disp;
      if (r_rd_pend) r_nxt_q <= mem_rdata;
      // Swap in the prefetched cell so it is live for x[2:0]==0.
      if (!active || (x[2:0] == 3'd7)) r_cell_q <= r_nxt_q;
      r_pix_color <= active ? r_cell_q : '0;
      r_last_addr <= mem_addr;
    end
  end

  assign pix_color = r_pix_color;

endmodule
